// File: rtl/imem_pkg.sv
// +----------------------------------------------------------------------------+
// | imem_pkg : shared widths, requester ids and read-tag type for imem_arbiter |
// | Optional: IMEM_OUTREG_EN selects BSRAM pipeline mode (read latency 2).     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package imem_pkg;

    localparam int IMEM_ADDR_W = 11;
    localparam int IMEM_DATA_W = 32;

`ifdef IMEM_OUTREG_EN
    localparam int IMEM_RD_LAT = 2;
`else
    localparam int IMEM_RD_LAT = 1;
`endif

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LOAD  = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } tag_t;

    // Drops a fetch tag while a flush is active; loader tags pass untouched.
    function automatic tag_t kill_fetch(input tag_t t, input logic flush);
        tag_t r;
        r = t;
        if (flush && (t.id == REQ_FETCH)) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | imem_arbiter_if : fetch, loader and BSRAM signal bundle for imem_arbiter   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface imem_arbiter_if #(
    parameter int ADDR_W = imem_pkg::IMEM_ADDR_W,
    parameter int DATA_W = imem_pkg::IMEM_DATA_W
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_flush;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_hold;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic              mem_ce;
    logic              mem_oce;
    logic              mem_wre;
    logic              mem_reset;
    logic [ADDR_W-1:0] mem_ad;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  f_req, f_addr, f_flush,
        input  l_req, l_we, l_addr, l_wdata, l_hold,
        input  mem_dout,
        output f_gnt, f_rvalid, f_rdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_ce, mem_oce, mem_wre, mem_reset, mem_ad, mem_din
    );

    modport master (
        output f_req, f_addr, f_flush,
        output l_req, l_we, l_addr, l_wdata, l_hold,
        output mem_dout,
        input  f_gnt, f_rvalid, f_rdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_ce, mem_oce, mem_wre, mem_reset, mem_ad, mem_din
    );

endinterface

`default_nettype wire

// File: rtl/imem_resp_pipe.sv
// +----------------------------------------------------------------------------+
// | imem_resp_pipe : read-tag shift register, flush drops fetch tags in flight |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module imem_resp_pipe
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_RD_LAT
) (
    input  wire  clk,
    input  wire  reset,
    input  tag_t i_push,
    input  wire  i_flush,
    output tag_t o_tag
);

    tag_t [DEPTH-1:0] r_stage_q;
    tag_t [DEPTH-1:0] w_stage_d;

    // The tag entering this cycle belongs to an access accepted alongside the
    // flush, so it is loaded unfiltered; older stages are filtered as they move.
    always_comb begin
        w_stage_d    = '0;
        w_stage_d[0] = i_push;
        for (int i = 1; i < DEPTH; i++) begin
            w_stage_d[i] = kill_fetch(r_stage_q[i-1], i_flush);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage_q <= '0;
        end else begin
            r_stage_q <= w_stage_d;
        end
    end

    assign o_tag = kill_fetch(r_stage_q[DEPTH-1], i_flush);

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// +----------------------------------------------------------------------------+
// | imem_arbiter : round-robin fetch/loader sharing of the 2048x32 imem BSRAM  |
// | Optional: IMEM_OUTREG_EN (via imem_pkg) for pipelined BSRAM, latency 2.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input wire            clk,
    input wire            reset,
    imem_arbiter_if.slave bus
);

    logic              w_f_elig;
    logic              w_l_elig;
    logic              w_f_gnt;
    logic              w_l_gnt;
    logic [ADDR_W-1:0] w_mem_ad;
    logic [DATA_W-1:0] w_mem_din;
    req_id_e           r_last_gnt_q;
    req_id_e           w_last_gnt_d;
    tag_t              w_push;
    tag_t              w_head;

    always_comb begin
        w_f_elig     = bus.f_req && !bus.l_hold;
        w_l_elig     = bus.l_req;
        w_f_gnt      = 1'b0;
        w_l_gnt      = 1'b0;
        w_last_gnt_d = r_last_gnt_q;

        // On a tie the requester not served last wins.
        if (w_f_elig && w_l_elig) begin
            w_f_gnt = (r_last_gnt_q == REQ_LOAD);
            w_l_gnt = (r_last_gnt_q == REQ_FETCH);
        end else begin
            w_f_gnt = w_f_elig;
            w_l_gnt = w_l_elig;
        end

        if (w_f_gnt) begin
            w_last_gnt_d = REQ_FETCH;
        end else if (w_l_gnt) begin
            w_last_gnt_d = REQ_LOAD;
        end

        w_push.valid = w_f_gnt || (w_l_gnt && !bus.l_we);
        w_push.id    = w_l_gnt ? REQ_LOAD : REQ_FETCH;

        w_mem_ad  = w_f_gnt ? bus.f_addr : bus.l_addr;
        w_mem_din = bus.l_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_gnt_q <= REQ_LOAD;
        end else begin
            r_last_gnt_q <= w_last_gnt_d;
        end
    end

    imem_resp_pipe #(
        .DEPTH (IMEM_RD_LAT)
    ) u_resp_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_flush (bus.f_flush),
        .o_tag   (w_head)
    );

    assign bus.f_gnt     = w_f_gnt;
    assign bus.l_gnt     = w_l_gnt;
    assign bus.f_rvalid  = w_head.valid && (w_head.id == REQ_FETCH);
    assign bus.l_rvalid  = w_head.valid && (w_head.id == REQ_LOAD);
    assign bus.f_rdata   = bus.mem_dout;
    assign bus.l_rdata   = bus.mem_dout;

    assign bus.mem_ce    = w_f_gnt || w_l_gnt;
    assign bus.mem_wre   = w_l_gnt && bus.l_we;
    assign bus.mem_oce   = 1'b1;
    assign bus.mem_reset = reset;
    assign bus.mem_ad    = w_mem_ad;
    assign bus.mem_din   = w_mem_din;

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_imem_arbiter : scoreboard bench for imem_arbiter with a BSRAM model     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int LAT = IMEM_RD_LAT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_arbiter_if bus ();

    imem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural BSRAM: address registered on the edge, normal write mode.
    logic [31:0] mem_arr [2048];
    logic [31:0] shadow  [2048];
    logic [31:0] dout_s1 = 32'h0;
    logic [31:0] dout_s2 = 32'h0;

    always @(posedge clk) begin
        if (bus.mem_ce) begin
            if (bus.mem_wre) mem_arr[bus.mem_ad] <= bus.mem_din;
            else             dout_s1 <= mem_arr[bus.mem_ad];
        end
        if (bus.mem_oce) dout_s2 <= dout_s1;
    end
`ifdef IMEM_OUTREG_EN
    assign bus.mem_dout = dout_s2;
`else
    assign bus.mem_dout = dout_s1;
`endif

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t fq[$];
    exp_t lq[$];
    logic m_last = 1'b1;
    logic m_gf, m_gl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs, then predict grants and responses from the rules.
    task automatic step(input logic fr, input logic [10:0] fa, input logic ff,
                        input logic lr, input logic lw, input logic [10:0] la,
                        input logic [31:0] ld, input logic lh);
        exp_t tmp[$];
        logic fe;
        @(negedge clk);
        bus.f_req = fr; bus.f_addr = fa; bus.f_flush = ff;
        bus.l_req = lr; bus.l_we = lw; bus.l_addr = la; bus.l_wdata = ld; bus.l_hold = lh;
        #1;
        fe = fr && !lh;
        m_gf = 1'b0; m_gl = 1'b0;
        if (fe && lr) begin
            m_gf = m_last;
            m_gl = !m_last;
        end else begin
            m_gf = fe;
            m_gl = lr;
        end
        chk("f_gnt", 32'(bus.f_gnt), 32'(m_gf));
        chk("l_gnt", 32'(bus.l_gnt), 32'(m_gl));
        chk("mem_ce", 32'(bus.mem_ce), 32'(m_gf | m_gl));
        chk("mem_wre", 32'(bus.mem_wre), 32'(m_gl & lw));
        chk("mem_ad", 32'(bus.mem_ad), 32'(m_gf ? fa : la));
        if (ff) begin
            foreach (fq[i]) if (fq[i].due >= cyc + LAT) tmp.push_back(fq[i]);
            fq = tmp;
        end
        if (m_gf) begin
            fq.push_back('{cyc + LAT, shadow[fa]});
            m_last = 1'b0;
        end
        if (m_gl) begin
            if (lw) shadow[la] = ld;
            else    lq.push_back('{cyc + LAT, shadow[la]});
            m_last = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.f_req = 1'b0; bus.l_req = 1'b0; bus.f_flush = 1'b0; bus.l_hold = 1'b0;
        reset = 1'b1;
        fq.delete();
        lq.delete();
        m_last = 1'b1;
        #1;
        chk("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
        chk("rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        chk("rst_mem_reset", 32'(bus.mem_reset), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pops the expected response whenever the DUT presents one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (bus.f_rvalid) begin
                    checks++;
                    if (fq.size() == 0) begin
                        errors++;
                        $display("FAIL f_resp: unexpected f_rvalid data %h (cycle %0d)", bus.f_rdata, cyc);
                    end else begin
                        e = fq.pop_front();
                        if (e.due != cyc || bus.f_rdata !== e.data) begin
                            errors++;
                            $display("FAIL f_resp: got %h at cycle %0d, expected %h at cycle %0d", bus.f_rdata, cyc, e.data, e.due);
                        end
                    end
                end
                if (bus.l_rvalid) begin
                    checks++;
                    if (lq.size() == 0) begin
                        errors++;
                        $display("FAIL l_resp: unexpected l_rvalid data %h (cycle %0d)", bus.l_rdata, cyc);
                    end else begin
                        e = lq.pop_front();
                        if (e.due != cyc || bus.l_rdata !== e.data) begin
                            errors++;
                            $display("FAIL l_resp: got %h at cycle %0d, expected %h at cycle %0d", bus.l_rdata, cyc, e.data, e.due);
                        end
                    end
                end
                while (fq.size() > 0 && fq[0].due <= cyc) begin
                    checks++; errors++;
                    e = fq.pop_front();
                    $display("FAIL f_missing: got no f_rvalid, expected %h at cycle %0d", e.data, e.due);
                end
                while (lq.size() > 0 && lq[0].due <= cyc) begin
                    checks++; errors++;
                    e = lq.pop_front();
                    $display("FAIL l_missing: got no l_rvalid, expected %h at cycle %0d", e.data, e.due);
                end
            end
        end
    end

    initial begin
        logic pf, pl, plw;
        logic [10:0] pfa, pla;
        logic [31:0] pld;
        for (int i = 0; i < 2048; i++) begin
            mem_arr[i] = 32'hC0DE_0000 + 32'(i) * 32'h0001_0003;
            shadow[i]  = 32'hC0DE_0000 + 32'(i) * 32'h0001_0003;
        end
        bus.f_req = 1'b0; bus.f_addr = '0; bus.f_flush = 1'b0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0; bus.l_hold = 1'b0;

        #2;
        chk("init_f_rvalid", 32'(bus.f_rvalid), 32'd0);
        chk("init_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        chk("init_mem_oce", 32'(bus.mem_oce), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Fetch only, back to back
        for (int a = 0; a < 4; a++) step(1'b1, 11'(a), 1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 1'b0);
        idle(LAT + 1);

        // Contention right after reset: fetch must win the first tie
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 11'd8, 1'b0, 1'b1, 1'b0, 11'd9, 32'd0, 1'b0);
        idle(LAT + 1);

        // Loader write then immediate readback
        step(1'b0, 11'd0, 1'b0, 1'b1, 1'b1, 11'h7FF, 32'hDEADBEEF, 1'b0);
        step(1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 11'h7FF, 32'd0, 1'b0);
        idle(LAT + 1);

        // Hold: fetch starved while the loader programs 16 words
        for (int i = 0; i < 16; i++)
            step(1'b1, 11'd3, 1'b0, 1'b1, 1'b1, 11'(100 + i), $urandom, 1'b1);
        step(1'b1, 11'd3, 1'b0, 1'b1, 1'b0, 11'd105, 32'd0, 1'b0);
        chk("hold_release_f_gnt", 32'(bus.f_gnt), 32'd1);
        idle(LAT + 2);

        // Flush of an in-flight fetch; the fetch issued with the flush survives
        step(1'b1, 11'd5, 1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 1'b0);
        for (int i = 1; i < LAT; i++) idle(1);
        step(1'b1, 11'd6, 1'b1, 1'b0, 1'b0, 11'd0, 32'd0, 1'b0);
        chk("flush_f_rvalid", 32'(bus.f_rvalid), 32'd0);
        idle(LAT + 1);

        // Reset the cycle after an accepted read, then check the first tie
        step(1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 11'd12, 32'd0, 1'b0);
        do_reset();
        step(1'b1, 11'd1, 1'b0, 1'b1, 1'b0, 11'd2, 32'd0, 1'b0);
        chk("post_reset_tie", 32'(bus.f_gnt), 32'd1);
        idle(LAT + 1);

        // Randomized traffic; requesters hold their request until granted
        pf = 1'b0; pl = 1'b0; pfa = '0; pla = '0; plw = 1'b0; pld = '0;
        for (int n = 0; n < 500; n++) begin
            if (!pf) begin
                pf  = ($urandom_range(0, 3) != 0);
                pfa = 11'($urandom_range(0, 31));
            end
            if (!pl) begin
                pl  = ($urandom_range(0, 2) == 0);
                plw = 1'($urandom_range(0, 1));
                pla = 11'($urandom_range(0, 31));
                pld = $urandom;
            end
            step(pf, pfa, ($urandom_range(0, 7) == 0), pl, plw, pla, pld, ($urandom_range(0, 5) == 0));
            if (m_gf) pf = 1'b0;
            if (m_gl) pl = 1'b0;
        end
        idle(LAT + 2);
        chk("drain_empty", 32'(fq.size() + lq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port 2048x32 instruction BSRAM (imem8k) between two requesters: the CPU instruction fetch port and the boot/debug loader port.
- The loader can read and write; fetch is read-only.
- The block arbitrates one access per cycle, drives the BSRAM control pins, and returns read data with a per-requester valid signal.
- The block supports loader hold for bulk programming and fetch flush on branch redirect.

Parameters:
- ADDR_W, 11, word address width (2048 words).
- DATA_W, 32, data width.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch read request.
- f_addr  in  ADDR_W  fetch word address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_flush  in  1  discard fetch responses already in flight.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  DATA_W  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) or read (0).
- l_addr  in  ADDR_W  loader word address.
- l_wdata  in  DATA_W  loader write data.
- l_hold  in  1  block all fetch grants while high.
- l_gnt  out  1  loader request accepted.
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  DATA_W  loader read data.
- mem_ce, mem_oce, mem_wre  out  1 each  BSRAM controls.
- mem_reset  out  1  BSRAM output-latch reset.
- mem_ad  out  ADDR_W  BSRAM address.
- mem_din  out  DATA_W  BSRAM write data.
- mem_dout  in  DATA_W  BSRAM read data.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. The clock port is named clk and the reset port is named reset.
- Grants:
  - Grants are combinational from current requests and registered state.
  - A request is accepted when req && gnt.
  - At most one grant per cycle.
- Eligibility:
  - Fetch is eligible iff f_req && !l_hold.
  - Loader is eligible iff l_req.
- Arbitration:
  - One eligible requester: grant it.
  - Both eligible: round-robin. Register last_gnt (0 = fetch, 1 = loader); grant the one not last granted.
  - last_gnt updates only on an accepted access.
  - Sustained contention therefore alternates F,L,F,L.
- Memory drive:
  - mem_ce = f_gnt | l_gnt.
  - mem_wre = l_gnt & l_we.
  - mem_ad and mem_din come from the granted requester; they equal the loader's values when idle.
  - mem_oce = 1.
  - mem_reset = reset.
- Read latency RD_LAT = 1 cycle:
  - A tag pipeline of depth RD_LAT records {valid, id} for each accepted read.
  - Writes create no tag.
  - f_rvalid / l_rvalid assert exactly RD_LAT cycles after acceptance, for one cycle.
  - f_rdata = l_rdata = mem_dout. Data is valid only while the matching rvalid is high.
- Flush:
  - f_flush clears every in-flight fetch tag, including the one emerging in the same cycle, so f_rvalid is forced 0 that cycle.
  - A fetch accepted in the same cycle as f_flush is not killed.
  - Loader tags are unaffected.
- l_hold: fetch gets no grant; in-flight fetch responses still complete.
- Write then read of the same address on consecutive cycles returns the new data (BSRAM write-mode normal).
- Reset (async, may hit mid-access):
  - Tag pipeline cleared; f_rvalid = l_rvalid = 0.
  - last_gnt = 1, so fetch wins the first tie.
  - Grants follow inputs after reset release.
- No internal backpressure: a requester holds req/addr/wdata until gnt.

Optional Feature:
- IMEM_OUTREG_EN defined: the BSRAM is instantiated in pipeline mode (output register on).
  - RD_LAT = 2; tag pipeline depth 2.
  - mem_oce = 1 always, so the output register advances every cycle.
  - f_flush kills both pipeline stages.
- Undefined: bypass mode, RD_LAT = 1 as above.

Decomposition:
- Package imem_pkg:
  - IMEM_ADDR_W = 11 and IMEM_DATA_W = 32.
  - Requester id typedef {REQ_FETCH = 0, REQ_LOAD = 1}.
  - IMEM_RD_LAT, derived from IMEM_OUTREG_EN.
  - Tag struct {valid, id}.
- One sub-module: imem_resp_pipe, a depth-RD_LAT tag shift register with flush-by-id and async reset. The arbiter core and mux stay in imem_arbiter.

Test Plan:
- Fetch only: f_req at addr 0..3 back to back -> f_gnt each cycle; f_rvalid on cycles 1..4 (2..5 with OUTREG); data = init words; l_rvalid never asserted.
- Contention: f_req and l_req (read) both held 6 cycles after reset -> grants F,L,F,L,F,L; responses tagged correctly in the same order.
- Loader write then readback: write 0xDEADBEEF to 0x7FF, next cycle read 0x7FF -> l_rvalid with 0xDEADBEEF; mem_wre high only on the write cycle.
- l_hold: l_hold=1 with f_req held, loader writing 16 words -> f_gnt stays 0 throughout; after l_hold drops, f_gnt on the next cycle.
- Flush: fetch accepted at cycle N, f_flush at N+RD_LAT -> no f_rvalid for it; fetch accepted in the flush cycle returns normally.
- Reset mid-read: assert reset the cycle after an accepted read -> rvalids 0 immediately; after release, first tie goes to fetch.
